// File: rtl/ysyx_220053_pipe_stage.sv
// Registered valid/ready pipeline stage with synchronous flush.
// Define YSYX_220053_SKID_EN for a 2-entry skid buffer; the default is a single register.
module ysyx_220053_pipe_stage #(
  parameter int unsigned DATA_W         = 96,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              accept, deliver;

  assign deliver   = main_valid_q & out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

`ifdef YSYX_220053_SKID_EN

  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = ~skid_valid_q & ~flush & ~rst;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end
    end else if (deliver) begin
      if (skid_valid_q) begin
        // Skid full means in_ready was low, so nothing new arrives this cycle.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

`else

  assign in_ready  = (~main_valid_q | out_ready) & ~flush & ~rst;
  assign occupancy = {1'b0, main_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    if (flush) begin
      main_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
      end
    end else if (accept) begin
      main_d       = in_data;
      main_valid_d = 1'b1;
    end else if (deliver) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
    end
  end

`endif

endmodule
